// File: rtl/bias_act_pkg.sv
// bias_act_pkg: shared FSM encoding, register offsets and Q16.16 saturation limits
package bias_act_pkg;
    typedef enum logic [2:0] {IDLE, RD_IN, WT_IN, RD_B, WT_B, WR, DONE} state_t;
    localparam logic [3:0] OFF_CTRL = 4'd0;
    localparam logic [3:0] OFF_IN = 4'd1;
    localparam logic [3:0] OFF_BIAS = 4'd2;
    localparam logic [3:0] OFF_OUT = 4'd3;
    localparam logic [3:0] OFF_LEN = 4'd5;
    localparam logic [31:0] Q_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] Q_MIN = 32'h8000_0000;
endpackage

// File: rtl/bias_act_if.sv
// bias_act_if: register-slave and memory-master bus bundle; slave = engine side, master = host/memory side
interface bias_act_if;
    logic slave_waitrequest;
    logic [3:0] slave_address;
    logic slave_read;
    logic slave_write;
    logic [31:0] slave_writedata;
    logic [31:0] slave_readdata;
    logic master_waitrequest;
    logic master_read;
    logic master_write;
    logic [31:0] master_address;
    logic [31:0] master_readdata;
    logic master_readdatavalid;
    logic [31:0] master_writedata;
    modport slave (
        output slave_waitrequest, slave_readdata, master_read, master_write, master_address, master_writedata,
        input slave_address, slave_read, slave_write, slave_writedata, master_waitrequest, master_readdata,
        master_readdatavalid
    );
    modport master (
        input slave_waitrequest, slave_readdata, master_read, master_write, master_address, master_writedata,
        output slave_address, slave_read, slave_write, slave_writedata, master_waitrequest, master_readdata,
        master_readdatavalid
    );
endinterface

// File: rtl/bias_act_q16_sat_add.sv
// q16_sat_add: combinational signed Q16.16 adder saturating to the 32-bit limits
module q16_sat_add
    import bias_act_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum
);
    logic [31:0] raw;
    always_comb begin
        raw = a + b;
        sum = (a[31] == b[31] && raw[31] != a[31]) ? (a[31] ? Q_MIN : Q_MAX) : raw;
    end
endmodule

// File: rtl/bias_act.sv
// bias_act: DMA engine computing out[i] = sat(in[i] + bias[i]) over memory vectors.
// Define BIAS_ACT_RELU_EN to clamp negative results to 0 and report the clamp count as the result.
module bias_act
    import bias_act_pkg::*;
(
    input logic clk,
    input logic rst_n,
    bias_act_if.slave bus
);
    state_t state;
    logic [31:0] in_base, b_base, out_base, len, idx, clamp, result, in_val, sum, act, nxt;
    logic neg;

    q16_sat_add u_add (.a(in_val), .b(bus.master_readdata), .sum(sum));

    always_comb begin
        neg = 1'b0;
        act = sum;
`ifdef BIAS_ACT_RELU_EN
        neg = sum[31];
        act = neg ? '0 : sum;
`endif
    end

    assign nxt = idx + 32'd1;
    assign bus.slave_waitrequest = state != IDLE;

    always_comb begin
        bus.slave_readdata = !bus.slave_read ? '0 :
                             bus.slave_address == OFF_CTRL ? result :
                             bus.slave_address == OFF_IN   ? in_base :
                             bus.slave_address == OFF_BIAS ? b_base :
                             bus.slave_address == OFF_OUT  ? out_base :
                             bus.slave_address == OFF_LEN  ? len : '0;
    end

    // Master strobes/address/data are registered and only change once the bus accepts them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            bus.master_read <= 1'b0;
            bus.master_write <= 1'b0;
            bus.master_address <= '0;
            bus.master_writedata <= '0;
            in_base <= '0;
            b_base <= '0;
            out_base <= '0;
            len <= '0;
            idx <= '0;
            clamp <= '0;
            result <= '0;
            in_val <= '0;
        end else begin
            case (state)
                IDLE: if (bus.slave_write) begin
                    case (bus.slave_address)
                        OFF_CTRL: begin
                            idx <= '0;
                            clamp <= '0;
                            if (len == '0) state <= DONE;
                            else begin
                                bus.master_read <= 1'b1;
                                bus.master_address <= in_base;
                                state <= RD_IN;
                            end
                        end
                        OFF_IN: in_base <= bus.slave_writedata;
                        OFF_BIAS: b_base <= bus.slave_writedata;
                        OFF_OUT: out_base <= bus.slave_writedata;
                        OFF_LEN: len <= bus.slave_writedata;
                        default: ;
                    endcase
                end
                RD_IN: if (!bus.master_waitrequest) begin
                    bus.master_read <= 1'b0;
                    state <= WT_IN;
                end
                WT_IN: if (bus.master_readdatavalid) begin
                    in_val <= bus.master_readdata;
                    bus.master_read <= 1'b1;
                    bus.master_address <= b_base + {idx[29:0], 2'b00};
                    state <= RD_B;
                end
                RD_B: if (!bus.master_waitrequest) begin
                    bus.master_read <= 1'b0;
                    state <= WT_B;
                end
                WT_B: if (bus.master_readdatavalid) begin
                    bus.master_write <= 1'b1;
                    bus.master_address <= out_base + {idx[29:0], 2'b00};
                    bus.master_writedata <= act;
                    clamp <= clamp + {31'b0, neg};
                    state <= WR;
                end
                WR: if (!bus.master_waitrequest) begin
                    bus.master_write <= 1'b0;
                    if (nxt < len) begin
                        idx <= nxt;
                        bus.master_read <= 1'b1;
                        bus.master_address <= in_base + {nxt[29:0], 2'b00};
                        state <= RD_IN;
                    end else state <= DONE;
                end
                DONE: begin
                    result <= clamp;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bias_act.sv
// tb_bias_act: scoreboard bench; stimulus pushes expected memory writes, a negedge monitor pops and compares
module tb_bias_act;
    import bias_act_pkg::*;
    localparam logic [31:0] IN_B = 32'h100, B_B = 32'h200, OUT_B = 32'h300;

    logic clk = 1'b0, rst_n = 1'b1;
    always #5 clk = ~clk;

    bias_act_if bus();
    bias_act dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    logic [3:0] sa = '0;
    logic sr = 1'b0, sw = 1'b0, mwr = 1'b0, rdv = 1'b0;
    logic [31:0] swd = '0, mrd = '0;
    assign bus.slave_address = sa;
    assign bus.slave_read = sr;
    assign bus.slave_write = sw;
    assign bus.slave_writedata = swd;
    assign bus.master_waitrequest = mwr;
    assign bus.master_readdatavalid = rdv;
    assign bus.master_readdata = mrd;

    logic [31:0] mem [0:1023];
    logic [63:0] sb[$];
    int checks = 0, errors = 0, n_rd = 0, n_wr = 0, rd_lat = 1, rd_cnt = 0, wr_stall = 0, wcnt = 0;
    logic [31:0] rd_addr = '0, cap_a = '0, cap_d = '0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Memory model and write monitor: reads return after rd_lat cycles, writes stall wr_stall cycles
    always @(negedge clk) begin
        logic [63:0] e;
        rdv = 1'b0;
        if (rd_cnt > 0) begin
            rd_cnt--;
            if (rd_cnt == 0) begin
                rdv = 1'b1;
                mrd = mem[rd_addr[11:2]];
            end
        end
        if (bus.master_read && !mwr) begin
            n_rd++;
            rd_addr = bus.master_address;
            rd_cnt = rd_lat;
        end
        if (bus.master_write) begin
            if (wcnt == 0) begin
                cap_a = bus.master_address;
                cap_d = bus.master_writedata;
            end else begin
                check("wr_addr_stable", bus.master_address, cap_a);
                check("wr_data_stable", bus.master_writedata, cap_d);
            end
            if (wcnt < wr_stall) begin
                mwr = 1'b1;
                wcnt++;
            end else begin
                mwr = 1'b0;
                wcnt = 0;
                n_wr++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: addr %h data %h, none expected", bus.master_address, bus.master_writedata);
                end else begin
                    e = sb.pop_front();
                    check("wr_addr", bus.master_address, e[63:32]);
                    check("wr_data", bus.master_writedata, e[31:0]);
                end
            end
        end else mwr = 1'b0;
    end

    task automatic bus_wait(output int cyc);
        cyc = 0;
        while (bus.slave_waitrequest && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 2000) begin
            checks++;
            errors++;
            $display("FAIL slave_timeout: waitrequest still %b, required 0", bus.slave_waitrequest);
        end
    endtask

    task automatic host_write(input logic [3:0] a, input logic [31:0] d);
        int c;
        sa = a;
        swd = d;
        sw = 1'b1;
        bus_wait(c);
        @(negedge clk);
        sw = 1'b0;
    endtask

    task automatic host_read(input logic [3:0] a, output logic [31:0] d, output int c);
        sa = a;
        sr = 1'b1;
        bus_wait(c);
        #1 d = bus.slave_readdata;
        @(negedge clk);
        sr = 1'b0;
    endtask

    task automatic load(input int i, input logic [31:0] x, input logic [31:0] b, input logic [31:0] ex);
        mem[IN_B / 4 + i] = x;
        mem[B_B / 4 + i] = b;
        sb.push_back({OUT_B + 32'(i * 4), ex});
    endtask

    task automatic setup(input logic [31:0] n);
        host_write(OFF_IN, IN_B);
        host_write(OFF_BIAS, B_B);
        host_write(OFF_OUT, OUT_B);
        host_write(OFF_LEN, n);
    endtask

    task automatic run(input string nm, input logic [31:0] eres, input int n_exp);
        logic [31:0] r;
        int c, w0;
        w0 = n_wr;
        host_write(OFF_CTRL, 32'd1);
        host_read(OFF_CTRL, r, c);
        check({nm, "_result"}, r, eres);
        check({nm, "_writes"}, n_wr - w0, n_exp);
        check({nm, "_sb_empty"}, sb.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] r, eres;
        int c, r0, w0;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        sr = 1'b1;
        #1;
        check("rst_slave_wait", bus.slave_waitrequest, 0);
        check("rst_master_read", bus.master_read, 0);
        check("rst_master_write", bus.master_write, 0);
        check("rst_master_addr", bus.master_address, 0);
        check("rst_master_wdata", bus.master_writedata, 0);
        check("rst_readdata", bus.slave_readdata, 0);
        sr = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        host_write(OFF_IN, 32'h0000_0140);
        host_read(OFF_IN, r, c);
        check("cfg_readback", r, 32'h0000_0140);
        host_read(4'd4, r, c);
        check("unmapped_read", r, 0);

        load(0, 32'h0001_0000, 32'h0000_4000, 32'h0001_4000);
`ifdef BIAS_ACT_RELU_EN
        load(1, 32'hFFFD_8000, 32'h0001_0000, 32'h0000_0000);
        load(2, 32'h0000_8000, 32'hFFFF_0000, 32'h0000_0000);
        eres = 32'd2;
`else
        load(1, 32'hFFFD_8000, 32'h0001_0000, 32'hFFFE_8000);
        load(2, 32'h0000_8000, 32'hFFFF_0000, 32'hFFFF_8000);
        eres = 32'd0;
`endif
        wr_stall = 3;
        setup(32'd3);
        run("vec3", eres, 3);
        wr_stall = 0;

        load(0, 32'h7FFF_0000, 32'h0002_0000, 32'h7FFF_FFFF);
`ifdef BIAS_ACT_RELU_EN
        load(1, 32'h8001_0000, 32'hFFFE_0000, 32'h0000_0000);
        eres = 32'd1;
`else
        load(1, 32'h8001_0000, 32'hFFFE_0000, 32'h8000_0000);
        eres = 32'd0;
`endif
        setup(32'd2);
        run("sat", eres, 2);

        r0 = n_rd;
        w0 = n_wr;
        host_write(OFF_LEN, 32'd0);
        host_write(OFF_CTRL, 32'd1);
        host_read(OFF_CTRL, r, c);
        check("len0_result", r, 0);
        check("len0_latency_ok", c <= 3, 1);
        check("len0_reads", n_rd - r0, 0);
        check("len0_writes", n_wr - w0, 0);

        // Abort while waiting on the bias read: the long read latency keeps the engine in WT_B
        rd_lat = 6;
        setup(32'd3);
        r0 = n_rd;
        w0 = n_wr;
        sa = OFF_CTRL;
        swd = 32'd1;
        sw = 1'b1;
        @(negedge clk);
        sw = 1'b0;
        for (int k = 0; k < 50 && n_rd < r0 + 2; k++) @(negedge clk);
        check("abort_reads_before", n_rd - r0, 2);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_master_read", bus.master_read, 0);
        check("abort_master_write", bus.master_write, 0);
        check("abort_slave_wait", bus.slave_waitrequest, 0);
        check("abort_master_addr", bus.master_address, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("abort_writes_after", n_wr - w0, 0);
        check("abort_reads_after", n_rd - r0, 2);
        host_read(OFF_IN, r, c);
        check("abort_cfg_cleared", r, 0);
        host_read(OFF_CTRL, r, c);
        check("abort_result", r, 0);
        check("abort_sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bias_act.md
BIAS_ACT -- requirements
Module: bias_act

Interface
REQ-001 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-002 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port slave_waitrequest  output  1  slave stall.
REQ-004 SHALL have port slave_address  input  4  word offset.
REQ-005 SHALL have ports slave_read, slave_write  input  1 each  slave strobes.
REQ-006 SHALL have ports slave_writedata  input  32 and slave_readdata  output  32.
REQ-007 SHALL have port master_waitrequest  input  1  master stall.
REQ-008 SHALL have ports master_read, master_write  output  1 each  master strobes.
REQ-009 SHALL have port master_address  output  32  byte address.
REQ-010 SHALL have ports master_readdata  input  32 and master_readdatavalid  input  1  read return.
REQ-011 SHALL have port master_writedata  output  32  store data.

Function
REQ-012 SHALL decode slave word offsets: 0 start (write) / result (read); 1 input-vector base; 2 bias-vector base; 3 output-vector base; 5 length in elements; others ignored, read as 0.
REQ-013 SHALL implement states IDLE, RD_IN, WT_IN, RD_B, WT_B, WR, DONE.
REQ-014 SHALL leave IDLE for RD_IN on any slave write to offset 0; index i and clamp count cleared.
REQ-015 SHALL, per element i, read input at in_base+4i, then bias at b_base+4i, then write result to out_base+4i.
REQ-016 SHALL hold master_read/master_write, address and writedata stable while master_waitrequest=1; a request completes on the cycle it is high with master_waitrequest=0.
REQ-017 SHALL leave WT_IN/WT_B only on master_readdatavalid=1, capturing master_readdata that cycle; at most one outstanding read.
REQ-018 SHALL compute sum as signed Q16.16 add, saturated to 0x7FFFFFFF / 0x80000000 on overflow.
REQ-019 SHALL go WR->RD_IN while i+1<length, else WR->DONE; DONE->IDLE after one cycle.
REQ-020 SHALL treat length 0 as start->DONE with no master transaction and result 0.
REQ-021 SHALL assert slave_waitrequest in every state except IDLE, for both reads and writes.
REQ-022 SHALL drive slave_readdata at offset 0 from a result register updated in DONE (clamp count), stable in IDLE.
REQ-023 SHALL ignore config writes arriving while busy (they stall; applied only once IDLE).

Reset
REQ-024 SHALL on rst_n=0 immediately force IDLE, slave_waitrequest=0, master_read=0, master_write=0, master_address=0, master_writedata=0, slave_readdata=0, all config/result registers 0.
REQ-025 SHALL abort an in-flight job on mid-run reset with no further master transactions; late readdatavalid ignored.

Configuration
REQ-026 SHALL, with BIAS_ACT_RELU_EN defined, replace negative saturated sums with 0 and count each clamp into result.
REQ-027 SHALL, without BIAS_ACT_RELU_EN, write the saturated sum unchanged and result always 0.

Structure
REQ-028 SHALL place state enum, register-offset constants and Q16.16 saturation limits in shared package bias_act_pkg.
REQ-029 SHALL isolate saturating adder in sub-module q16_sat_add (combinational, 32-bit in/out).

Verification
REQ-030 SHALL cover: RELU_EN, len=3, in {0x00010000,0xFFFD8000,0x00008000}, bias {0x00004000,0x00010000,0xFFFF0000} -> writes 0x00014000,0,0; read offset 0 returns 2.
REQ-031 SHALL cover: in 0x7FFF0000 + bias 0x00020000 -> write 0x7FFFFFFF; in 0x80010000 + bias 0xFFFE0000 -> 0x80000000 (without RELU_EN).
REQ-032 SHALL cover: len=0 start -> no master_read/master_write ever asserted, offset-0 read returns 0 within 3 cycles.
REQ-033 SHALL cover: master_waitrequest held 3 cycles on each write -> address/data stable, exactly 3 writes total for len=3.
REQ-034 SHALL cover: rst_n low during WT_B -> master strobes 0 same cycle, slave_waitrequest 0, no writes after reset.
REQ-035 SHALL cover: without RELU_EN, REQ-030 stimulus -> writes 0x00014000,0xFFFE8000,0xFFFF8000; result 0.
